// File: rtl/codec_cfg_pkg.sv
// rtl/codec_cfg_pkg.sv - shared types, WM8731 init table and volume word helper
package codec_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PWR_WAIT,
        ST_ISSUE,
        ST_WAIT_RSP,
        ST_NEXT,
        ST_RUN,
        ST_FAIL
    } state_t;

    localparam int ROM_DEPTH = 10;

    // {reg[6:0], data[8:0]}: reset, line-in, headphone L/R, analog path,
    // digital path, power-down (all on), I2S 16-bit format, sample rate, active
    localparam logic [15:0] INIT_ROM [ROM_DEPTH] = '{
        16'h1E00,
        16'h0017,
        16'h0579,
        16'h0779,
        16'h0812,
        16'h0A00,
        16'h0C00,
        16'h0E02,
        16'h1000,
        16'h1201
    };

    localparam logic [6:0] VOL_REG = 7'h02;

    // Entries past the table read as zero so a larger INIT_LEN never indexes out of range
    function automatic logic [15:0] rom_word(input int idx);
        if (idx < ROM_DEPTH) begin
            return INIT_ROM[idx];
        end
        return 16'h0000;
    endfunction

    // Headphone volume: both-channel update bit set, attenuation of 4 steps per code
    function automatic logic [15:0] vol_word(input logic [3:0] k);
        logic [6:0] att;
        att = 7'h7F - {1'b0, k, 2'b00};
        return {VOL_REG, 2'b10, att};
    endfunction

endpackage

// File: rtl/codec_cfg_seq_timer.sv
// rtl/codec_cfg_seq_timer.sv - loadable down-counter for power-up wait and transfer timeout
module cfg_timer #(
    parameter int W = 20
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority; otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/codec_cfg_seq.sv
// rtl/codec_cfg_seq.sv - WM8731 I2C init sequencer with UART volume updates
module codec_cfg_seq
    import codec_cfg_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         INIT_LEN  = 10,
    parameter int         PWR_DLY   = 500000,
    parameter int         TIMEOUT   = 100000,
    parameter int         MAX_RETRY = 3
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic        start,
    input  logic        k_valid,
    input  logic [3:0]  k_code,
    output logic        iic_req,
    output logic [6:0]  iic_dev,
    output logic [15:0] iic_word,
    input  logic        iic_done,
    input  logic        iic_nack,
    output logic        busy,
    output logic        init_done,
    output logic        error
);

    localparam int DLY_MAX = (PWR_DLY > TIMEOUT) ? PWR_DLY : TIMEOUT;
    localparam int TW      = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
    localparam int IW      = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
    localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    // Timer runs load..0, so load N-1 to spend exactly N cycles in the waiting state
    localparam logic [TW-1:0] PWR_LOAD = TW'((PWR_DLY > 0) ? PWR_DLY - 1 : 0);
    localparam logic [TW-1:0] TO_LOAD  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX = IW'((INIT_LEN > 0) ? INIT_LEN - 1 : 0);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          req_q, req_d;
    logic [15:0]   word_q, word_d;
    logic          init_done_q, init_done_d;
    logic          error_q, error_d;
    logic          pend_q, pend_d;
    logic [3:0]    pend_code_q, pend_code_d;
    logic [3:0]    cur_code_q, cur_code_d;
    logic          vol_q, vol_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;

    cfg_timer #(
        .W(TW)
    ) u_timer (
        .clk_i      (clk_50m),
        .rst_ni     (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // Next-state and datapath decisions; the pending volume latch is updated first
    // so individual states can override it (consume in RUN, discard in FAIL)
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        req_d       = req_q;
        word_d      = word_q;
        init_done_d = init_done_q;
        error_d     = error_q;
        pend_d      = pend_q;
        pend_code_d = pend_code_q;
        cur_code_d  = cur_code_q;
        vol_d       = vol_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        if (k_valid) begin
            pend_d      = 1'b1;
            pend_code_d = k_code;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_PWR_WAIT;
                    idx_d    = '0;
                    retry_d  = '0;
                    tmr_load = 1'b1;
                    tmr_val  = PWR_LOAD;
                end
            end
            ST_PWR_WAIT: begin
                if (tmr_zero) begin
                    state_d = ST_ISSUE;
                    idx_d   = '0;
                    vol_d   = 1'b0;
                end
            end
            ST_ISSUE: begin
                req_d    = 1'b1;
                word_d   = vol_q ? vol_word(cur_code_q) : rom_word(int'(idx_q));
                tmr_load = 1'b1;
                tmr_val  = TO_LOAD;
                state_d  = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (iic_done) begin
                    req_d   = 1'b0;
                    retry_d = '0;
                    state_d = ST_NEXT;
                end else if (iic_nack || tmr_zero) begin
                    req_d = 1'b0;
                    if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_NEXT: begin
                if (vol_q) begin
                    vol_d   = 1'b0;
                    state_d = ST_RUN;
                end else if (idx_q < LAST_IDX) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    init_done_d = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pend_q) begin
                    cur_code_d = pend_code_q;
                    vol_d      = 1'b1;
                    pend_d     = k_valid;
                    state_d    = ST_ISSUE;
                end
            end
            ST_FAIL: begin
                error_d = 1'b1;
                req_d   = 1'b0;
                pend_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            retry_q     <= '0;
            req_q       <= 1'b0;
            word_q      <= 16'h0000;
            init_done_q <= 1'b0;
            error_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_code_q <= 4'h0;
            cur_code_q  <= 4'h0;
            vol_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            req_q       <= req_d;
            word_q      <= word_d;
            init_done_q <= init_done_d;
            error_q     <= error_d;
            pend_q      <= pend_d;
            pend_code_q <= pend_code_d;
            cur_code_q  <= cur_code_d;
            vol_q       <= vol_d;
        end
    end

    assign iic_req   = req_q;
    assign iic_dev   = DEV_ADDR;
    assign iic_word  = word_q;
    assign init_done = init_done_q;
    assign error     = error_q;
    assign busy      = !((state_q == ST_IDLE) || ((state_q == ST_RUN) && !pend_q));

endmodule

// File: tb/tb_codec_cfg_seq.sv
// tb/tb_codec_cfg_seq.sv - self-checking bench for codec_cfg_seq
module tb_codec_cfg_seq;

    localparam int         PWR_DLY   = 8;
    localparam int         TIMEOUT   = 20;
    localparam int         MAX_RETRY = 3;
    localparam int         INIT_LEN  = 10;
    localparam logic [6:0] DEV       = 7'h1A;

    logic        clk_50m = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        k_valid = 1'b0;
    logic [3:0]  k_code = 4'h0;
    logic        iic_done = 1'b0;
    logic        iic_nack = 1'b0;
    logic        iic_req;
    logic [6:0]  iic_dev;
    logic [15:0] iic_word;
    logic        busy;
    logic        init_done;
    logic        error;

    codec_cfg_seq #(
        .DEV_ADDR  (DEV),
        .INIT_LEN  (INIT_LEN),
        .PWR_DLY   (PWR_DLY),
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .start     (start),
        .k_valid   (k_valid),
        .k_code    (k_code),
        .iic_req   (iic_req),
        .iic_dev   (iic_dev),
        .iic_word  (iic_word),
        .iic_done  (iic_done),
        .iic_nack  (iic_nack),
        .busy      (busy),
        .init_done (init_done),
        .error     (error)
    );

    always #10 clk_50m = ~clk_50m;

    int cyc = 0;
    always @(posedge clk_50m) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // WM8731 register/data pairs expected in order
    logic [15:0] rom_exp [10] = '{
        {7'h0F, 9'h000}, {7'h00, 9'h017}, {7'h02, 9'h179}, {7'h03, 9'h179},
        {7'h04, 9'h012}, {7'h05, 9'h000}, {7'h06, 9'h000}, {7'h07, 9'h002},
        {7'h08, 9'h000}, {7'h09, 9'h001}
    };

    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    int          obs_cyc[$];
    int          plan_q[$];   // 0 done, 1 nack, 2 silent, 3 done+nack together
    int          nack_cnt[10];
    int          both_entry;
    bit          exp_fail;
    bit          serve_to;
    int          drop_bad;

    function automatic logic [15:0] vol_exp(input int k);
        logic [8:0] d;
        d = 9'(383 - 4 * k);
        return {7'h02, d};
    endfunction

    // Expected issued words and the responder plan, derived from nack counts per entry
    task automatic build_init(input bit silent);
        exp_q.delete();
        plan_q.delete();
        exp_fail = 1'b0;
        for (int e = 0; e < INIT_LEN; e++) begin
            if (nack_cnt[e] > MAX_RETRY) begin
                repeat (MAX_RETRY + 1) begin
                    exp_q.push_back(rom_exp[e]);
                    plan_q.push_back(silent ? 2 : 1);
                end
                exp_fail = 1'b1;
                break;
            end
            repeat (nack_cnt[e]) begin
                exp_q.push_back(rom_exp[e]);
                plan_q.push_back(silent ? 2 : 1);
            end
            exp_q.push_back(rom_exp[e]);
            plan_q.push_back((e == both_entry) ? 3 : 0);
        end
    endtask

    // Emulated I2C master: answers up to n requests following plan_q
    task automatic serve(input int n);
        int  r;
        int  d;
        int  cnt;
        bit  seen;
        cnt = 0;
        while (plan_q.size() > 0 && cnt < n) begin
            seen = 1'b0;
            for (int i = 0; i < 400; i++) begin
                @(negedge clk_50m);
                if (iic_req) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) begin
                serve_to = 1'b1;
                return;
            end
            obs_q.push_back(iic_word);
            obs_cyc.push_back(cyc);
            r = plan_q.pop_front();
            cnt++;
            if (r == 2) begin
                seen = 1'b0;
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk_50m);
                    if (!iic_req) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (!seen) begin
                    serve_to = 1'b1;
                    return;
                end
            end else begin
                d = $urandom_range(0, 5);
                repeat (d) @(negedge clk_50m);
                iic_done = (r == 0 || r == 3);
                iic_nack = (r == 1 || r == 3);
                @(negedge clk_50m);
                iic_done = 1'b0;
                iic_nack = 1'b0;
                if (iic_req) drop_bad++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk_50m);
        rst_n    = 1'b0;
        start    = 1'b0;
        k_valid  = 1'b0;
        iic_done = 1'b0;
        iic_nack = 1'b0;
        repeat (3) @(negedge clk_50m);
        rst_n = 1'b1;
        @(negedge clk_50m);
        obs_q.delete();
        obs_cyc.delete();
        plan_q.delete();
        serve_to   = 1'b0;
        drop_bad   = 0;
        both_entry = -1;
        for (int e = 0; e < 10; e++) nack_cnt[e] = 0;
    endtask

    task automatic pulse_start(output int s);
        start = 1'b1;
        s = cyc;
        @(negedge clk_50m);
        start = 1'b0;
    endtask

    task automatic pulse_k(input logic [3:0] k);
        k_valid = 1'b1;
        k_code  = k;
        @(negedge clk_50m);
        k_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (iic_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", iic_req); end
        n_checks++; if (iic_word !== 16'h0) begin n_fail++; $display("FAIL reset_word got %h want 0000", iic_word); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done got %b want 0", init_done); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", error); end
        n_checks++; if (iic_dev !== DEV) begin n_fail++; $display("FAIL reset_dev got %h want %h", iic_dev, DEV); end
    endtask

    task automatic test_init_basic();
        int s;
        do_reset();
        build_init(1'b0);
        pulse_start(s);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_pwr got %b want 1", busy); end
        serve(100);
        repeat (2) @(negedge clk_50m);
        n_checks++; if (serve_to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got %b want 0", serve_to); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        if (obs_cyc.size() > 0) begin
            n_checks++; if (obs_cyc[0] - s != 10) begin n_fail++; $display("FAIL basic_first_req_cycle got %0d want 10", obs_cyc[0] - s); end
        end
        n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL basic_init_done got %b want 1", init_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy got %b want 0", busy); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL basic_error got %b want 0", error); end
        n_checks++; if (drop_bad != 0) begin n_fail++; $display("FAIL basic_req_drop got %0d late drops want 0", drop_bad); end
    endtask

    task automatic test_nack_retry();
        int s;
        int n3;
        do_reset();
        nack_cnt[3] = 2;
        both_entry  = 0;
        build_init(1'b0);
        pulse_start(s);
        serve(100);
        repeat (2) @(negedge clk_50m);
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL nack_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL nack_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n3 = 0;
        foreach (obs_q[i]) if (obs_q[i] === rom_exp[3]) n3++;
        n_checks++; if (n3 != 3) begin n_fail++; $display("FAIL nack_entry3_issues got %0d want 3", n3); end
        n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL nack_init_done got %b want 1", init_done); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL nack_error got %b want 0", error); end
        n_checks++; if (drop_bad != 0) begin n_fail++; $display("FAIL nack_req_drop got %0d want 0", drop_bad); end
    endtask

    task automatic test_nack_fail();
        int s;
        int rises;
        do_reset();
        nack_cnt[5] = 4;
        build_init(1'b0);
        pulse_start(s);
        serve(100);
        @(negedge clk_50m);
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fail_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL fail_error got %b want 1", error); end
        n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL fail_init_done got %b want 0", init_done); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fail_busy got %b want 1", busy); end
        rises = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i == 100) begin
                k_valid = 1'b1;
                k_code  = 4'h7;
            end else begin
                k_valid = 1'b0;
            end
            @(negedge clk_50m);
            if (iic_req) rises++;
        end
        n_checks++; if (rises != 0) begin n_fail++; $display("FAIL fail_req_quiet got %0d high cycles want 0", rises); end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL fail_error_held got %b want 1", error); end
    endtask

    task automatic test_volume_pending();
        int s;
        int rises;
        do_reset();
        build_init(1'b0);
        exp_q.push_back(vol_exp(9));
        plan_q.push_back(0);
        pulse_start(s);
        serve(3);
        pulse_k(4'd4);
        serve(4);
        pulse_k(4'd9);
        serve(100);
        rises = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_50m);
            if (iic_req) rises++;
        end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL vol_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL vol_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (rises != 0) begin n_fail++; $display("FAIL vol_extra_req got %0d want 0", rises); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL vol_busy got %b want 0", busy); end
        n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL vol_init_done got %b want 1", init_done); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] d0;
        logic [8:0] d1;
        obs_q.delete();
        plan_q.delete();
        plan_q.push_back(0);
        plan_q.push_back(0);
        k_valid = 1'b1;
        k_code  = 4'd0;
        @(negedge clk_50m);
        k_code  = 4'd15;
        @(negedge clk_50m);
        k_valid = 1'b0;
        serve(2);
        repeat (3) @(negedge clk_50m);
        n_checks++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", obs_q.size()); end
        if (obs_q.size() == 2) begin
            d0 = obs_q[0][8:0];
            d1 = obs_q[1][8:0];
            n_checks++; if (obs_q[0] !== vol_exp(0)) begin n_fail++; $display("FAIL b2b_word0 got %h want %h", obs_q[0], vol_exp(0)); end
            n_checks++; if (d0 !== 9'h17F) begin n_fail++; $display("FAIL b2b_k0_data got %h want 17f", d0); end
            n_checks++; if (d1 !== 9'h143) begin n_fail++; $display("FAIL b2b_k15_data got %h want 143", d1); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy got %b want 0", busy); end
    endtask

    task automatic test_timeout();
        int s;
        int gap;
        do_reset();
        nack_cnt[2] = 4;
        build_init(1'b1);
        pulse_start(s);
        serve(100);
        @(negedge clk_50m);
        n_checks++; if (serve_to !== 1'b0) begin n_fail++; $display("FAIL to_stall got %b want 0", serve_to); end
        n_checks++; if (obs_q.size() != 6) begin n_fail++; $display("FAIL to_count got %0d want 6", obs_q.size()); end
        for (int i = 3; i < obs_cyc.size(); i++) begin
            gap = obs_cyc[i] - obs_cyc[i-1];
            n_checks++; if (gap < TIMEOUT + 1 || gap > 2 * TIMEOUT) begin n_fail++; $display("FAIL to_gap[%0d] got %0d want %0d..%0d", i, gap, TIMEOUT + 1, 2 * TIMEOUT); end
        end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL to_error got %b want 1", error); end
        n_checks++; if (iic_req !== 1'b0) begin n_fail++; $display("FAIL to_req got %b want 0", iic_req); end
    endtask

    task automatic test_reset_mid();
        int  s;
        bit  seen;
        do_reset();
        build_init(1'b0);
        pulse_start(s);
        serve(2);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_50m);
            if (iic_req) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL mid_req_seen got %b want 1", seen); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({iic_req, busy, init_done, error} !== 4'b0) begin n_fail++; $display("FAIL mid_flags got %b want 0000", {iic_req, busy, init_done, error}); end
        n_checks++; if (iic_word !== 16'h0) begin n_fail++; $display("FAIL mid_word got %h want 0000", iic_word); end
        @(negedge clk_50m);
        rst_n = 1'b1;
        @(negedge clk_50m);
        obs_q.delete();
        build_init(1'b0);
        pulse_start(s);
        serve(100);
        repeat (2) @(negedge clk_50m);
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL mid_init_done got %b want 1", init_done); end
    endtask

    task automatic test_random();
        int s;
        int k;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int e = 0; e < INIT_LEN; e++) nack_cnt[e] = $urandom_range(0, 2);
            if ($urandom_range(0, 2) == 0) nack_cnt[$urandom_range(0, INIT_LEN - 1)] = 4;
            both_entry = $urandom_range(0, INIT_LEN - 1);
            build_init(1'b0);
            pulse_start(s);
            serve(200);
            repeat (2) @(negedge clk_50m);
            n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_count got %0d want %0d", it, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_word[%0d] got %h want %h", it, i, obs_q[i], exp_q[i]); end
            end
            n_checks++; if (error !== exp_fail) begin n_fail++; $display("FAIL rnd%0d_error got %b want %b", it, error, exp_fail); end
            n_checks++; if (init_done !== !exp_fail) begin n_fail++; $display("FAIL rnd%0d_init_done got %b want %b", it, init_done, !exp_fail); end
            if (!exp_fail) begin
                k = $urandom_range(0, 15);
                obs_q.delete();
                plan_q.push_back(0);
                pulse_k(4'(k));
                serve(1);
                repeat (2) @(negedge clk_50m);
                n_checks++; if (obs_q.size() != 1 || obs_q[0] !== vol_exp(k)) begin n_fail++; $display("FAIL rnd%0d_vol k=%0d got n=%0d w=%h want %h", it, k, obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 16'h0, vol_exp(k)); end
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_busy got %b want 0", it, busy); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        both_entry = -1;
        test_reset();
        test_init_basic();
        test_nack_retry();
        test_nack_fail();
        test_volume_pending();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/codec_cfg_seq.md
CODEC_CFG_SEQ -- requirements
Module: codec_cfg_seq

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'h1A, giving the codec 7-bit I2C device address.
REQ-002 The block SHALL have parameter INIT_LEN, default 10, giving the number of init-table entries.
REQ-003 The block SHALL have parameter PWR_DLY, default 500000, giving the power-up wait in clk_50m cycles before the first write.
REQ-004 The block SHALL have parameter TIMEOUT, default 100000, giving the cycles allowed per transfer before it counts as failed.
REQ-005 The block SHALL have parameter MAX_RETRY, default 3, giving the retries per entry after the first attempt.
REQ-006 The block SHALL have input clk_50m, 1 bit: system clock, the block's only clock.
REQ-007 The block SHALL have input rst_n, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have input start, 1 bit: one-cycle pulse that begins the init sequence.
REQ-009 The block SHALL have input k_valid, 1 bit: one-cycle strobe indicating a new UART volume code.
REQ-010 The block SHALL have input k_code, 4 bits: UART volume code, sampled when k_valid=1.
REQ-011 The block SHALL have output iic_req, 1 bit: write request to the I2C master, held until done or nack.
REQ-012 The block SHALL have output iic_dev, 7 bits: device address, always equal to DEV_ADDR.
REQ-013 The block SHALL have output iic_word, 16 bits: {reg[6:0], data[8:0]}, stable while iic_req=1.
REQ-014 The block SHALL have input iic_done, 1 bit: one-cycle pulse meaning the transfer was acknowledged.
REQ-015 The block SHALL have input iic_nack, 1 bit: one-cycle pulse meaning the transfer was not acknowledged.
REQ-016 The block SHALL have outputs busy, init_done and error, 1 bit each: status flags.

Function
REQ-017 States SHALL be IDLE, PWR_WAIT, ISSUE, WAIT_RSP, NEXT, RUN and FAIL.
REQ-018 In IDLE, start SHALL move the FSM to PWR_WAIT and clear its counters; start in any other state SHALL be ignored.
REQ-019 PWR_WAIT SHALL count PWR_DLY cycles and then enter ISSUE with index=0.
REQ-020 ISSUE SHALL assert iic_req with iic_word=INIT_ROM[index] on the next cycle and then enter WAIT_RSP.
REQ-021 In WAIT_RSP, iic_done SHALL drop iic_req in the same edge, reset the retry count and go to NEXT.
REQ-022 In WAIT_RSP, iic_nack or a timeout count reaching TIMEOUT SHALL drop iic_req and retry (back to ISSUE) while retry<MAX_RETRY, else go to FAIL.
REQ-023 If iic_done and iic_nack arrive in the same cycle, iic_done SHALL win.
REQ-024 NEXT SHALL go to ISSUE with index+1 if index<INIT_LEN-1, else go to RUN and set init_done=1.
REQ-025 In RUN with a pending volume code, the block SHALL issue iic_word={7'h02, 2'b10, 7'h7F-{k,2'b00}} using the ISSUE/WAIT_RSP path, then return to RUN.
REQ-026 Range check: k=0 SHALL give data 0x17F and k=15 SHALL give 0x143.
REQ-027 k_valid in any state SHALL latch k_code into a 1-deep pending register; a newer code SHALL overwrite an unserviced one.
REQ-028 A k_valid arriving in the same cycle the pending code is consumed SHALL re-set pending with the new code.
REQ-029 FAIL SHALL set error=1, hold iic_req=0 and stay there until reset.
REQ-030 Pending codes in FAIL SHALL be discarded.
REQ-031 busy SHALL be 1 in every state except IDLE and RUN-with-no-pending.
REQ-032 iic_req SHALL rise at most once per attempt, and SHALL stay low for at least 1 cycle between attempts.

Reset
REQ-033 rst_n low SHALL asynchronously force state=IDLE, iic_req=0, iic_word=0, busy=0, init_done=0, error=0, and clear pending, index, retry and all counters.
REQ-034 Reset asserted mid-transfer SHALL drop iic_req immediately; I2C master recovery is the master's responsibility.

Structure
REQ-035 Package codec_cfg_pkg SHALL hold the state enum, the INIT_ROM constant array (WM8731 reset, power, format, sample-rate, active entries) and the volume register address constant.
REQ-036 One sub-module SHALL exist: cfg_timer, a loadable down-counter shared by PWR_WAIT and the timeout.

Verification
REQ-037 Reset, then start with PWR_DLY=8 -> iic_req rises at cycle 10; 10 ack'd words match INIT_ROM in order; init_done=1; busy=0.
REQ-038 NACK on entry 3 twice, then done -> entry 3 is issued 3 times, the sequence completes, error=0.
REQ-039 NACK on entry 5 four times -> FAIL, error=1, iic_req stays 0 for 1000 cycles.
REQ-040 k_valid with k=4 during init, then k=9 before init_done -> after entry 9, only word {7'h02, 9'h15B} is issued.
REQ-041 No iic_done or iic_nack with TIMEOUT=20 -> retries every 20+ cycles, then FAIL after 4 attempts.
REQ-042 rst_n pulsed low during WAIT_RSP -> all outputs 0 in the same cycle; a new start reruns from entry 0.
